// File: rtl/matmul_pkg.sv
// Definitions shared by the matmul PL write path and the output-memory drain.
package matmul_pkg;

    localparam int MM_ADDR_WIDTH  = 12;
    localparam int MM_NUM_RESULTS = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_FIN   = 2'd3
    } mm_state_e;

    // True while a drain owns the memory port or still has words to emit.
    function automatic logic mm_is_active(input mm_state_e st);
        return (st == ST_READ) || (st == ST_FLUSH);
    endfunction

endpackage

// File: rtl/drain_fifo.sv
// Small synchronous element FIFO; exposes its two oldest entries and can pop 0, 1 or 2 per cycle.
module drain_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic [1:0]            pop,
    output logic [CW-1:0]         count,
    output logic [DATA_WIDTH-1:0] head0,
    output logic [DATA_WIDTH-1:0] head1
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    assign head0 = mem[rd_ptr];
    assign head1 = mem[rd_ptr + 1'b1];

endmodule

// File: rtl/outmem_stream_drain.sv
// Reads the matmul output memory sequentially and streams result pairs as 32-bit AXI-Stream words.
module outmem_stream_drain
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = MM_ADDR_WIDTH,
    parameter int NUM_RESULTS = MM_NUM_RESULTS,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_dout,
    output logic [2*DATA_WIDTH-1:0] m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_RESULTS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_BEAT = ADDR_WIDTH'(NUM_RESULTS / 2 - 1);

    mm_state_e state;
    mm_state_e state_nxt;

    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [ADDR_WIDTH-1:0]   beat_cnt;
    logic                    rd_vld_p1;
    logic                    vld_p2;
    logic [2*DATA_WIDTH-1:0] word_p2;

    logic [CW-1:0]         fifo_count;
    logic [DATA_WIDTH-1:0] head0;
    logic [DATA_WIDTH-1:0] head1;
    logic                  fifo_push;
    logic [1:0]            fifo_pop;

    logic [CW:0]           credit;
    logic                  issue;
    logic                  issue_last;
    logic                  avail2;
    logic                  load;
    logic                  bypass;
    logic                  hs;
    logic                  last_hs;
    logic [DATA_WIDTH-1:0] elem1;

    drain_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_data(mem_dout),
        .pop      (fifo_pop),
        .count    (fifo_count),
        .head0    (head0),
        .head1    (head1)
    );

    // A word stalled in the output register still holds its two element credits.
    always_comb begin
        credit = (CW+1)'(fifo_count) + (CW+1)'(rd_vld_p1);
        if (vld_p2 && !m_tready) begin
            credit = credit + (CW+1)'(2);
        end
        issue      = (state == ST_READ) && (credit < (CW+1)'(FIFO_DEPTH));
        issue_last = issue && (rd_addr == LAST_ADDR);

        // The read returning this cycle may complete a pair without passing through the FIFO.
        avail2    = (fifo_count >= CW'(2)) || ((fifo_count == CW'(1)) && rd_vld_p1);
        load      = mm_is_active(state) && avail2 && (!vld_p2 || m_tready);
        bypass    = load && (fifo_count == CW'(1));
        elem1     = bypass ? mem_dout : head1;
        fifo_pop  = !load ? 2'd0 : (bypass ? 2'd1 : 2'd2);
        fifo_push = rd_vld_p1 && !bypass;

        hs      = vld_p2 && m_tready;
        last_hs = hs && (beat_cnt == LAST_BEAT);
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                busy = 1'b1;
                if (issue_last) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                busy = 1'b1;
                if (last_hs) begin
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rd_addr   <= '0;
            beat_cnt  <= '0;
            rd_vld_p1 <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_vld_p1 <= issue;
            if ((state == ST_IDLE) && start) begin
                rd_addr  <= '0;
                beat_cnt <= '0;
            end else begin
                if (issue && !issue_last) begin
                    rd_addr <= rd_addr + 1'b1;
                end
                if (hs) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    // Output stage: the packed pair waits here until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            word_p2 <= '0;
        end else if (load) begin
            vld_p2  <= 1'b1;
            word_p2 <= {elem1, head0};
        end else if (m_tready) begin
            vld_p2  <= 1'b0;
        end
    end

    assign mem_en   = issue;
    assign mem_addr = rd_addr;
    assign m_tdata  = word_p2;
    assign m_tvalid = vld_p2;
    assign m_tlast  = vld_p2 && (beat_cnt == LAST_BEAT);

endmodule

// File: tb/tb_outmem_stream_drain.sv
// Bench for outmem_stream_drain: small 8-result instance for corner cases, default instance for a full matrix.
module tb_outmem_stream_drain;

    localparam int DW = 16;
    localparam int AW = 12;
    localparam int NS = 8;
    localparam int NB = NS / 2;
    localparam int BIG_NB = 2048;

    typedef struct packed {
        logic [31:0] tdata;
        logic        tlast;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic          a_start = 1'b0, a_busy, a_done, a_mem_en, a_tvalid, a_tready = 1'b0, a_tlast;
    logic [AW-1:0] a_mem_addr;
    logic [DW-1:0] a_mem_dout = '0;
    logic [31:0]   a_tdata;

    logic          b_start = 1'b0, b_busy, b_done, b_mem_en, b_tvalid, b_tready = 1'b0, b_tlast;
    logic [AW-1:0] b_mem_addr;
    logic [DW-1:0] b_mem_dout = '0;
    logic [31:0]   b_tdata;

    outmem_stream_drain #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RESULTS(NS), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
        .mem_en(a_mem_en), .mem_addr(a_mem_addr), .mem_dout(a_mem_dout),
        .m_tdata(a_tdata), .m_tvalid(a_tvalid), .m_tready(a_tready), .m_tlast(a_tlast)
    );

    outmem_stream_drain dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
        .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_dout(b_mem_dout),
        .m_tdata(b_tdata), .m_tvalid(b_tvalid), .m_tready(b_tready), .m_tlast(b_tlast)
    );

    // Output memory models: memory[i] = i for the small instance, a scrambled pattern for the large one.
    function automatic logic [15:0] bval(input int i);
        return 16'(i) ^ 16'hA5C3;
    endfunction

    always @(posedge clk) if (a_mem_en) a_mem_dout <= DW'(a_mem_addr);
    always @(posedge clk) if (b_mem_en) b_mem_dout <= bval(int'(b_mem_addr));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    beat_t vec[NB];
    beat_t a_q[$];
    beat_t b_q[$];

    int a_mode = 2;
    int a_tcnt = 0;
    bit b_rnd = 1'b0;

    initial forever begin
        @(posedge clk); #1;
        case (a_mode)
            0:       a_tready = 1'b1;
            1:       a_tready = (a_tcnt % 3 == 0);
            default: a_tready = 1'b0;
        endcase
        a_tcnt++;
        b_tready = b_rnd ? ($urandom_range(0, 3) != 0) : 1'b0;
    end

    int          a_reads = 0, a_hs = 0, a_dones = 0, b_beats = 0;
    logic        a_stall = 1'b0, a_slast = 1'b0, a_lasths = 1'b0;
    logic [31:0] a_sdata = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            a_reads  <= 0;
            a_hs     <= 0;
            a_stall  <= 1'b0;
            a_lasths <= 1'b0;
        end else begin
            if (a_mem_en) chk("a_addr_bound", a_mem_addr > AW'(NS - 1), 0);
            chk("a_reads_plus_fifo", (a_reads + int'(a_mem_en) - 2 * (a_hs + int'(a_tvalid))) > 4, 0);
            if (a_stall) begin
                chk("a_hold_valid", a_tvalid, 1);
                chk("a_hold_tdata", a_tdata, a_sdata);
                chk("a_hold_tlast", a_tlast, a_slast);
            end
            if (a_tvalid) begin
                chk("a_beat_expected", a_q.size() == 0, 0);
                if (a_q.size() > 0) begin
                    chk("a_tdata", a_tdata, a_q[0].tdata);
                    chk("a_tlast", a_tlast, a_q[0].tlast);
                    if (a_tready) void'(a_q.pop_front());
                end
            end
            if (a_done || a_lasths) chk("a_done_timing", a_done, a_lasths);
            if (a_mem_en) a_reads <= a_reads + 1;
            if (a_tvalid && a_tready) a_hs <= a_hs + 1;
            if (a_done) a_dones <= a_dones + 1;
            a_stall  <= a_tvalid & ~a_tready;
            a_sdata  <= a_tdata;
            a_slast  <= a_tlast;
            a_lasths <= a_tvalid & a_tready & a_tlast;
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_tvalid) begin
            chk("b_beat_expected", b_q.size() == 0, 0);
            if (b_q.size() > 0) begin
                chk("b_tdata", b_tdata, b_q[0].tdata);
                chk("b_tlast", b_tlast, b_q[0].tlast);
                if (b_tready) begin
                    void'(b_q.pop_front());
                    b_beats <= b_beats + 1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic start_a(input bit expect_stream);
        if (expect_stream) foreach (vec[k]) a_q.push_back(vec[k]);
        a_start = 1'b1;
        cyc();
        a_start = 1'b0;
    endtask

    // Called right after start_a: start -> mem_en is 1 cycle, mem_en -> m_tvalid is 3 cycles.
    task automatic check_first_a();
        chk("lat_mem_en", a_mem_en, 1);
        chk("lat_mem_addr0", a_mem_addr, 0);
        chk("lat_busy", a_busy, 1);
        chk("lat_tvalid_c1", a_tvalid, 0);
        cyc(); cyc();
        chk("lat_tvalid_c3", a_tvalid, 0);
        cyc();
        chk("lat_tvalid_c4", a_tvalid, 1);
        chk("lat_first_word", a_tdata, 32'h00010000);
    endtask

    task automatic wait_done_a(input string name);
        int n = 0;
        while (!a_done && n < 300) begin cyc(); n++; end
        chk(name, a_done, 1);
    endtask

    task automatic wait_hs_a(input int target, input string name);
        int n = 0;
        while (a_hs < target && n < 100) begin cyc(); n++; end
        chk(name, a_hs >= target, 1);
    endtask

    task automatic check_reset_a(input string name);
        chk({name, "_busy"}, a_busy, 0);
        chk({name, "_done"}, a_done, 0);
        chk({name, "_mem_en"}, a_mem_en, 0);
        chk({name, "_mem_addr"}, a_mem_addr, 0);
        chk({name, "_tvalid"}, a_tvalid, 0);
        chk({name, "_tlast"}, a_tlast, 0);
        chk({name, "_tdata"}, a_tdata, 0);
    endtask

    int run_mode[2] = '{0, 1};

    initial begin
        int h0, d0, r0, n;
        vec[0] = '{tdata: 32'h00010000, tlast: 1'b0};
        vec[1] = '{tdata: 32'h00030002, tlast: 1'b0};
        vec[2] = '{tdata: 32'h00050004, tlast: 1'b0};
        vec[3] = '{tdata: 32'h00070006, tlast: 1'b1};

        cyc();
        check_reset_a("rst");
        chk("rst_b_busy", b_busy, 0);
        chk("rst_b_tvalid", b_tvalid, 0);
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();

        // Free-running and toggling-ready drains from the run table
        for (int i = 0; i < 2; i++) begin
            a_mode = run_mode[i];
            d0 = a_dones;
            chk("run_idle_busy", a_busy, 0);
            start_a(1'b1);
            check_first_a();
            wait_done_a("run_done");
            chk("run_all_beats", a_q.size(), 0);
            cyc();
            chk("run_busy_after", a_busy, 0);
            chk("run_one_done", a_dones - d0, 1);
            repeat (2) cyc();
        end

        // Backpressure from the start: four reads, then the port goes quiet
        a_mode = 2;
        r0 = a_reads;
        start_a(1'b1);
        repeat (50) cyc();
        chk("bp_reads", a_reads - r0, 4);
        chk("bp_mem_en_quiet", a_mem_en, 0);
        chk("bp_word_held", a_tdata, 32'h00010000);
        a_mode = 0;
        wait_done_a("bp_done");
        chk("bp_all_beats", a_q.size(), 0);
        repeat (3) cyc();

        // start during beat 2 and on the FIN cycle is ignored; start two cycles after done is not
        d0 = a_dones;
        h0 = a_hs;
        start_a(1'b1);
        wait_hs_a(h0 + 1, "ign_beat1");
        start_a(1'b0);
        wait_done_a("ign_done");
        start_a(1'b0);
        chk("fin_start_busy", a_busy, 0);
        chk("fin_start_mem_en", a_mem_en, 0);
        chk("ign_one_done", a_dones - d0, 1);
        cyc();
        start_a(1'b1);
        check_first_a();
        wait_done_a("second_done");
        chk("second_all_beats", a_q.size(), 0);
        repeat (20) cyc();
        chk("second_dones", a_dones - d0, 2);
        chk("second_idle", a_busy, 0);

        // Reset after two beats discards everything; a new start drains from address 0
        d0 = a_dones;
        h0 = a_hs;
        a_mode = 1;
        start_a(1'b1);
        wait_hs_a(h0 + 2, "mid_two_beats");
        rst_n = 1'b0;
        #1;
        check_reset_a("mid_rst");
        a_q.delete();
        cyc();
        chk("mid_rst_tvalid", a_tvalid, 0);
        rst_n = 1'b1;
        cyc();
        chk("mid_rst_no_done", a_dones - d0, 0);
        a_mode = 0;
        start_a(1'b1);
        check_first_a();
        wait_done_a("post_rst_done");
        chk("post_rst_all_beats", a_q.size(), 0);
        repeat (3) cyc();

        // Full default-size matrix under random ready
        for (int k = 0; k < BIG_NB; k++)
            b_q.push_back('{tdata: {bval(2 * k + 1), bval(2 * k)}, tlast: (k == BIG_NB - 1)});
        b_rnd = 1'b1;
        b_start = 1'b1;
        cyc();
        b_start = 1'b0;
        n = 0;
        while (!b_done && n < 30000) begin cyc(); n++; end
        chk("big_done", b_done, 1);
        chk("big_beats", b_beats, BIG_NB);
        chk("big_queue_empty", b_q.size(), 0);
        cyc();
        chk("big_busy_after", b_busy, 0);
        chk("big_done_pulse", b_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
